// File: rtl/btn_cmd_scheduler.sv
// Pushbutton front end: synchronise, debounce and edge-detect N_BTN buttons, then arbitrate presses into a command FIFO.
// Define BTN_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority with the lowest index winning.
module btn_cmd_scheduler #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    localparam int IDW  = (N_BTN > 2) ? $clog2(N_BTN) : 1,
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic             cmd_valid,
    output logic [IDW-1:0]   cmd_id,
    input  logic             cmd_ready,
    output logic [CNTW-1:0]  fifo_count,
    output logic             overflow
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [N_BTN-1:0] s1, s2, deb, pending, rise, grant_mask;
    logic [CW-1:0]    cnt [N_BTN];
    logic             grant_vld, fifo_full, push, pop;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    // A rise is the cycle the debounce counter expires while the debounced level is still low.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            rise[i] = !deb[i] && s2[i] && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            for (int i = 0; i < N_BTN; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign fifo_full = (fifo_count == CNTW'(FIFO_DEPTH));

`ifdef BTN_ROUND_ROBIN_EN
    logic [IDW-1:0] last_grant;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            if (!grant_vld && pending[(int'(last_grant) + 1 + k) % N_BTN]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'((int'(last_grant) + 1 + k) % N_BTN);
            end
        end
        if (fifo_full) grant_vld = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IDW'(N_BTN - 1);
        end else if (grant_vld) begin
            last_grant <= grant_id;
        end
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            if (!grant_vld && pending[k]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(k);
            end
        end
        if (fifo_full) grant_vld = 1'b0;
    end
`endif

    assign grant_mask = grant_vld ? (N_BTN'(1) << grant_id) : '0;

    // A grant and a fresh rise on the same button in one cycle re-arms pending without counting as lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~grant_mask) | rise;
            if (|(rise & pending & ~grant_mask)) overflow <= 1'b1;
        end
    end

    // Handshake: the head is transferred on any edge where cmd_valid and cmd_ready are both high;
    // while cmd_valid is high and cmd_ready low, cmd_id holds the same head entry.
    assign push      = grant_vld;
    assign cmd_valid = (fifo_count != '0);
    assign pop       = cmd_valid && cmd_ready;
    assign cmd_id    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) mem[j] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= grant_id;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNTW'(1);
                2'b01:   fifo_count <= fifo_count - CNTW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: doc/btn_cmd_scheduler.md
# btn_cmd_scheduler

Front-end controller for the board pushbuttons. It synchronises, debounces and rising-edge-detects `N_BTN` raw button inputs, arbitrates simultaneous presses and queues one command per press into a small FIFO. Downstream FSMs consume commands over a valid/ready handshake. The block replaces the per-button edge detectors with one shared, ordered command stream.

## Interface
- `N_BTN`, default 4: number of buttons, ≥2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the debounced level changes, ≥1.
- `FIFO_DEPTH`, default 4: command queue depth, power of two ≥2.
- `clk`, input, 1: single clock.
- `reset`, input, 1: synchronous, active-high.
- `btn`, input, `N_BTN`: raw asynchronous button levels, active-high.
- `cmd_valid`, output, 1: queue head holds a command.
- `cmd_id`, output, `IDW = max(1, $clog2(N_BTN))`: index of the pressed button at queue head.
- `cmd_ready`, input, 1: consumer accepts the head on this edge when `cmd_valid`=1.
- `fifo_count`, output, `$clog2(FIFO_DEPTH)+1`: number of queued commands.
- `overflow`, output, 1: sticky; a press was lost. Cleared only by `reset`.

## Operation
- **Synchroniser:** two flops per button (`s1`, `s2`).
- **Debounce:** each button has a counter and a debounced level `deb[i]`.
  - When `s2[i] == deb[i]`, the counter is set to 0.
  - Otherwise the counter increments. When `s2[i] != deb[i]` has held for `DEBOUNCE_CYCLES` consecutive cycles, `deb[i] <= s2[i]` and the counter is set to 0.
- **Edge and pending bits:**
  - On the edge where `deb[i]` goes 0→1, `pending[i]` is set.
  - If `pending[i]` is already 1 at that point, the press is coalesced and `overflow` is set to 1.
- **Arbiter:** each cycle, if any `pending` bit is set and the FIFO is not full, exactly one request is granted. The granted `pending` bit is cleared and its index is written to the FIFO.
- **FIFO full:** requests wait in `pending`. No grant is made while `fifo_count == FIFO_DEPTH`, even if a pop occurs in the same cycle.
- **Arbiter and edge in the same cycle:** a grant of `pending[i]` and a new rising edge on button `i` in the same cycle leave `pending[i]` = 1, with no overflow.
- **FIFO:** show-ahead, so `cmd_id` = head entry whenever `cmd_valid`=1. `cmd_valid = (fifo_count != 0)`. A pop occurs on `cmd_valid & cmd_ready`.
  - Simultaneous push and pop leave `fifo_count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Handshake:** `cmd_id` is held stable while `cmd_valid`=1 and `cmd_ready`=0.
- **Reset:** all state returns to zero: sync flops, `deb`, counters, `pending`, FIFO, `overflow`. The round-robin pointer resets to `N_BTN-1`. Outputs after reset: `cmd_valid`=0, `cmd_id`=0, `fifo_count`=0, `overflow`=0.
- **Button held through reset:** a button held high through reset yields one new press after reset is released. Reset asserted mid-operation discards all queued and pending commands at that edge.

## Timing
- Edge 0 is the first edge at which `btn[i]`=1 is sampled, with the button stable afterwards:
  - `s2[i]` = 1 after edge 1.
  - `deb[i]` and `pending[i]` = 1 after edge `1+DEBOUNCE_CYCLES`.
  - FIFO write and `cmd_valid`=1 after edge `2+DEBOUNCE_CYCLES` (edge 6 for the defaults).
- Release is debounced identically. It generates no command.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles never changes `deb`.
- Throughput is at most one grant per cycle and one pop per cycle.

## Configuration
- `BTN_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at index `last_grant+1`, wrapping modulo `N_BTN`.
  - `last_grant` updates on every grant.
- Not defined: fixed priority, lowest index wins. The pointer logic is absent.

## Test plan
- **Single press:** `btn`=0001 held 12 cycles, `cmd_ready`=1 → `cmd_valid`=1 for exactly one cycle starting after edge 6 (defaults), `cmd_id`=0. No second command on release.
- **Bounce:** `btn[1]` toggles every 2 cycles for 12 cycles, then stays high → exactly one command with `cmd_id`=1. No command during the toggling.
- **Simultaneous press:** press `btn[1]` alone and drain it, then press 1111 together with `cmd_ready`=1 →
  - Round robin: `cmd_id` sequence 2,3,0,1 on consecutive cycles.
  - Fixed priority: 0,1,2,3.
- **Backpressure:**
  - `cmd_ready`=0, press 1111 and release → `fifo_count`=4.
  - Press `btn[0]` → it waits in `pending`.
  - Press `btn[0]` again after a debounced release → `overflow`=1.
  - `cmd_ready`=1 → 5 commands drain with 0 last, and `overflow` stays 1.
- **Reset mid-queue:** `fifo_count`=2, assert `reset` for 1 cycle while `btn[2]` is held high →
  - `cmd_valid`=0, `fifo_count`=0, `overflow`=0 after the reset edge.
  - Exactly one `cmd_id`=2 appears 6 edges after reset is released.
